load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execution stage.
- Accepts one load/store request per instruction and runs a request/grant/response handshake on the data bus.
- Performs byte-lane steering and load sign/zero extension, and produces the register write-back for loads.
- Asserts hold to the pipeline control while a transaction is outstanding, and flags misaligned or illegal accesses instead of issuing them.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in REQ or RESP before the timeout fault fires (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid_i  input  1  execution stage presents a memory instruction
- req_we_i  input  1  1=store, 0=load
- funct3_i  input  3  RV32I width/sign code
- addr_i  input  32  effective byte address
- wdata_i  input  32  store data (rs2)
- rd_addr_i  input  5  load destination register
- flush_i  input  1  pipeline flush (jump/interrupt)
- bus_req_o  output  1  bus request
- bus_we_o  output  1  bus write
- bus_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata_o  output  32  lane-steered store data
- bus_be_o  output  4  byte enables
- bus_gnt_i  input  1  bus grant
- bus_rvalid_i  input  1  read data valid
- bus_rdata_i  input  32  read data
- hold_o  output  1  stall request to pipeline control
- reg_wr_en_o  output  1  load write-back strobe
- reg_wr_addr_o  output  5  write-back register
- reg_wr_data_o  output  32  extended load data
- fault_o  output  1  one-cycle misaligned/illegal pulse
- fault_addr_o  output  32  faulting address

Behaviour:
- Reset values: every output 0; state IDLE. Reset is asynchronous at any state; an in-flight transaction is abandoned.
- States: IDLE, REQ, RESP, WB.
- IDLE:
  - On req_valid_i && !flush_i, capture we, funct3, addr, wdata, rd.
  - Legal request → REQ. Illegal request → stay in IDLE; fault_o=1 and fault_addr_o=addr_i on the next cycle.
  - hold_o = req_valid_i && legal, combinational.
- Legality:
  - Loads: funct3 ∈ {0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU}.
  - Stores: funct3 ∈ {0 SB, 1 SH, 2 SW}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Any other combination is illegal.
- REQ:
  - bus_req_o=1; bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o held stable until grant; hold_o=1.
  - On bus_gnt_i, stores → IDLE and loads → RESP.
  - bus_req_o drops the cycle after grant.
- RESP:
  - hold_o=1.
  - On bus_rvalid_i, register the extended data → WB. rvalid in the same cycle as grant is not supported; rvalid is earliest one cycle after grant.
- WB:
  - reg_wr_en_o=1 for exactly one cycle with reg_wr_addr_o/reg_wr_data_o; hold_o=0; → IDLE.
  - reg_wr_en_o is suppressed when rd=0.
  - Minimum load latency is 3 cycles from accept to write-back when grant is immediate.
- Byte enables and store data:
  - SB: be=4'b0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = halfword replicated ×2.
  - SW: be=4'b1111.
  - Loads drive be=4'b1111.
- Load extension:
  - Select the byte/halfword by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Flush:
  - In IDLE, a request is ignored.
  - In REQ before grant, drop bus_req_o next cycle → IDLE, no write-back.
  - In REQ on the same cycle as grant, the transaction completes on the bus. A load continues to RESP; its data is discarded and there is no WB.
  - In RESP, stay until rvalid, then discard the data and go to IDLE with no write-back. Discarded responses must never leak into a later request.
- Back-to-back: a new request may be accepted in the cycle after WB or after the store-grant return to IDLE.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter clears on entry to REQ/RESP and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES: fault_o pulses with fault_addr_o = captured addr, bus_req_o drops, no write-back, → IDLE.
  - A late rvalid arriving while in IDLE is ignored.
- LSU_TIMEOUT_EN undefined: no counter; REQ/RESP wait indefinitely.

Test Plan:
- LW addr=0x100, gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF, rd=5 → bus_be_o=4'hF; reg_wr_en_o on cycle 3 with x5=0xDEADBEEF; hold_o high for cycles 1–2.
- LB addr=0x103, rdata=0x80FF_FF_FF → data 0xFFFFFF80; LBU at the same address → 0x00000080; LHU addr=0x102, rdata=0xBEEF1234 → 0x0000BEEF.
- SB addr=0x201, wdata=0x000000AB, gnt delayed 3 cycles → bus_be_o=4'b0010, bus_wdata_o=0xABABABAB stable for 4 cycles; no reg_wr_en_o; hold_o falls the cycle after grant.
- LW addr=0x102 → no bus_req_o; fault_o pulse with fault_addr_o=0x102. SH addr=0x305 → same behaviour.
- flush_i during RESP of LW rd=7, followed by rvalid → no reg_wr_en_o; the next LW returns its own data correctly.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, gnt never asserted → fault_o on cycle 16 in REQ, state returns to IDLE; assert rst_n low mid-RESP → all outputs 0 immediately.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: request/grant/response bus handshake, byte-lane steering and load extension.
// Optional REQ/RESP watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        hold_o,
    output logic        reg_wr_en_o,
    output logic [4:0]  reg_wr_addr_o,
    output logic [31:0] reg_wr_data_o,
    output logic        fault_o,
    output logic [31:0] fault_addr_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        discard_q;
    logic        legal;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        if (we) ok = !f3[2] && (f3[1:0] != 2'b11);
        else    ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        case (f3[1:0])
            2'b01:   ok = ok && !off[0];
            2'b10:   ok = ok && (off == 2'b00);
            default: ;
        endcase
        return ok;
    endfunction

    assign legal = is_legal(req_we_i, funct3_i, addr_i[1:0]);

    always_comb begin
        be_n = 4'hF;
        wd_n = wdata_i;
        if (req_we_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_n = 4'b0001 << addr_i[1:0];
                    wd_n = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_n = addr_i[1] ? 4'b1100 : 4'b0011;
                    wd_n = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Extension uses the captured offset/width; funct3[2] selects zero-extension.
    always_comb begin
        case (off_q)
            2'b00:   byte_sel = bus_rdata_i[7:0];
            2'b01:   byte_sel = bus_rdata_i[15:8];
            2'b10:   byte_sel = bus_rdata_i[23:16];
            default: byte_sel = bus_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (f3_q[1:0])
            2'b00:   ld_data = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
            2'b01:   ld_data = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
            default: ld_data = bus_rdata_i;
        endcase
    end

    always_comb begin
        case (state)
            IDLE:     hold_o = req_valid_i && legal;
            REQ:      hold_o = 1'b1;
            RESP:     hold_o = 1'b1;
            default:  hold_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_wdata_o   <= '0;
            bus_be_o      <= '0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= '0;
            fault_o       <= 1'b0;
            fault_addr_o  <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            rd_q          <= '0;
            discard_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            fault_o     <= 1'b0;
            reg_wr_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        if (legal) begin
                            state       <= REQ;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= req_we_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_be_o    <= be_n;
                            bus_wdata_o <= wd_n;
                            f3_q        <= funct3_i;
                            off_q       <= addr_i[1:0];
                            rd_q        <= rd_addr_i;
                            discard_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                            cnt         <= '0;
`endif
                        end else begin
                            fault_o      <= 1'b1;
                            fault_addr_o <= addr_i;
                        end
                    end
                end
                REQ: begin
                    // Grant wins over flush: the bus has already committed the access.
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        discard_q <= flush_i;
                        state     <= bus_we_o ? IDLE : RESP;
`ifdef LSU_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end else if (flush_i) begin
                        bus_req_o <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timeout) begin
                        bus_req_o    <= 1'b0;
                        fault_o      <= 1'b1;
                        fault_addr_o <= {bus_addr_o[31:2], off_q};
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (flush_i) discard_q <= 1'b1;
                    if (bus_rvalid_i) begin
                        if (discard_q || flush_i) begin
                            state <= IDLE;
                        end else begin
                            reg_wr_en_o   <= (rd_q != 5'd0);
                            reg_wr_addr_o <= rd_q;
                            reg_wr_data_o <= ld_data;
                            state         <= WB;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timeout) begin
                        fault_o      <= 1'b1;
                        fault_addr_o <= {bus_addr_o[31:2], off_q};
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected write-backs are queued at stimulus time and
// popped by a monitor whenever the DUT strobes reg_wr_en_o.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0, req_we_i = 1'b0, flush_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_req_o, bus_we_o, hold_o, reg_wr_en_o, fault_o;
    logic [31:0] bus_addr_o, bus_wdata_o, reg_wr_data_o, fault_addr_o;
    logic [3:0]  bus_be_o;
    logic [4:0]  reg_wr_addr_o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    wb_t mon_e;
    int  n_checks = 0;
    int  n_pass = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .hold_o(hold_o),
        .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o), .reg_wr_data_o(reg_wr_data_o),
        .fault_o(fault_o), .fault_addr_o(fault_addr_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && reg_wr_en_o) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL wb_unexpected: got x%0d=%h, want no write-back", reg_wr_addr_o, reg_wr_data_o);
            end else begin
                mon_e = sb_q.pop_front();
                if ({reg_wr_addr_o, reg_wr_data_o} !== {mon_e.rd, mon_e.data})
                    $display("FAIL wb_data: got x%0d=%h, want x%0d=%h", reg_wr_addr_o, reg_wr_data_o, mon_e.rd, mon_e.data);
                else n_pass++;
            end
        end
    end

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdat >> (8 * a[1:0]));
        h = 16'(rdat >> (16 * a[1]));
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'b0, b};
            3'd5:    return {16'b0, h};
            default: return rdat;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] rd);
        req_valid_i = 1'b1; req_we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; rd_addr_i = rd;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, hold_o, reg_wr_en_o,
             reg_wr_addr_o, reg_wr_data_o, fault_o, fault_addr_o} !== '0)
            $display("FAIL reset_outputs: got req=%b be=%h hold=%b wr=%b fault=%b, want all 0",
                     bus_req_o, bus_be_o, hold_o, reg_wr_en_o, fault_o);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [4:0] rd, input logic [31:0] rdat, input int gnt_dly);
        drive_req(1'b0, f3, a, 32'h0, rd);
        @(negedge clk);
        n_checks++;
        if (hold_o !== 1'b1) $display("FAIL %s_hold_accept: got %b want 1", name, hold_o); else n_pass++;
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            if (i == gnt_dly) bus_gnt_i = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, hold_o} !== {1'b1, 1'b0, 4'hF, a[31:2], 2'b00, 1'b1})
                $display("FAIL %s_req: got req=%b we=%b be=%h addr=%h hold=%b, want 1 0 f %h 1",
                         name, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, hold_o, {a[31:2], 2'b00});
            else n_pass++;
            step();
        end
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = rdat;
        if (rd != 5'd0) sb_q.push_back('{rd: rd, data: exp_load(f3, a, rdat)});
        @(negedge clk);
        n_checks++;
        if ({bus_req_o, hold_o} !== 2'b01)
            $display("FAIL %s_resp: got req=%b hold=%b, want 0 1", name, bus_req_o, hold_o);
        else n_pass++;
        step();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({reg_wr_en_o, hold_o} !== {rd != 5'd0, 1'b0})
            $display("FAIL %s_wb: got wr_en=%b hold=%b, want %b 0", name, reg_wr_en_o, hold_o, rd != 5'd0);
        else n_pass++;
        step();
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int gnt_dly,
                              input logic [3:0] be, input logic [31:0] bwd);
        drive_req(1'b1, f3, a, wd, 5'd0);
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            if (i == gnt_dly) bus_gnt_i = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o, hold_o} !==
                {1'b1, 1'b1, be, bwd, a[31:2], 2'b00, 1'b1})
                $display("FAIL %s_req%0d: got req=%b we=%b be=%b wd=%h addr=%h hold=%b, want be=%b wd=%h",
                         name, i, bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o, hold_o, be, bwd);
            else n_pass++;
            step();
        end
        bus_gnt_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_req_o, hold_o, reg_wr_en_o} !== 3'b000)
            $display("FAIL %s_done: got req=%b hold=%b wr_en=%b, want 000", name, bus_req_o, hold_o, reg_wr_en_o);
        else n_pass++;
        step();
    endtask

    task automatic test_illegal(input string name, input logic we, input logic [2:0] f3, input logic [31:0] a);
        drive_req(we, f3, a, 32'h5555_AAAA, 5'd3);
        @(negedge clk);
        n_checks++;
        if (hold_o !== 1'b0) $display("FAIL %s_hold: got %b want 0", name, hold_o); else n_pass++;
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fault_o, fault_addr_o, bus_req_o} !== {1'b1, a, 1'b0})
            $display("FAIL %s_fault: got fault=%b addr=%h req=%b, want 1 %h 0", name, fault_o, fault_addr_o, bus_req_o, a);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if ({fault_o, bus_req_o} !== 2'b00)
            $display("FAIL %s_pulse: got fault=%b req=%b, want 0 0", name, fault_o, bus_req_o);
        else n_pass++;
        step();
    endtask

    task automatic test_flush();
        // flush in IDLE: request ignored
        drive_req(1'b0, 3'd2, 32'h0000_0500, 32'h0, 5'd4);
        flush_i = 1'b1;
        step();
        req_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_req_o !== 1'b0) $display("FAIL flush_idle: got req=%b want 0", bus_req_o); else n_pass++;
        step();
        // flush in REQ before grant
        drive_req(1'b1, 3'd2, 32'h0000_0504, 32'h1, 5'd0);
        step();
        req_valid_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_req_o, hold_o} !== 2'b00) $display("FAIL flush_req: got req=%b hold=%b, want 0 0", bus_req_o, hold_o); else n_pass++;
        step();
        // flush with grant: load completes on the bus but is discarded
        drive_req(1'b0, 3'd2, 32'h0000_0508, 32'h0, 5'd6);
        step();
        req_valid_i = 1'b0; bus_gnt_i = 1'b1; flush_i = 1'b1;
        step();
        bus_gnt_i = 1'b0; flush_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h6666_6666;
        step();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({reg_wr_en_o, hold_o} !== 2'b00) $display("FAIL flush_gnt: got wr_en=%b hold=%b, want 0 0", reg_wr_en_o, hold_o); else n_pass++;
        step();
        // flush in RESP: rvalid arrives later, data discarded
        drive_req(1'b0, 3'd2, 32'h0000_0400, 32'h0, 5'd7);
        step();
        req_valid_i = 1'b0; bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hold_o !== 1'b1) $display("FAIL flush_resp_hold: got %b want 1", hold_o); else n_pass++;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_1111;
        step();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({reg_wr_en_o, hold_o} !== 2'b00) $display("FAIL flush_resp: got wr_en=%b hold=%b, want 0 0", reg_wr_en_o, hold_o); else n_pass++;
        step();
        test_load("after_flush", 3'd2, 32'h0000_0404, 5'd8, 32'h2222_2222, 0);
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 3'd2, 32'h0000_0800, 32'hCAFE_F00D, 5'd0);
        step();
        req_valid_i = 1'b0; bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        drive_req(1'b0, 3'd4, 32'h0000_0801, 32'h0, 5'd10);
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o} !== {1'b1, 1'b0, 32'h0000_0800})
            $display("FAIL b2b_accept: got req=%b we=%b addr=%h, want 1 0 00000800", bus_req_o, bus_we_o, bus_addr_o);
        else n_pass++;
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_9A00;
        sb_q.push_back('{rd: 5'd10, data: 32'h0000_009A});
        step();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (reg_wr_en_o !== 1'b1) $display("FAIL b2b_wb: got wr_en=%b want 1", reg_wr_en_o); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 3'd2, 32'h0000_0600, 32'h0, 5'd9);
        step();
        req_valid_i = 1'b0; bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, hold_o, reg_wr_en_o,
             reg_wr_addr_o, reg_wr_data_o, fault_o, fault_addr_o} !== '0)
            $display("FAIL reset_mid: got req=%b addr=%h be=%h hold=%b, want all 0", bus_req_o, bus_addr_o, bus_be_o, hold_o);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        step();
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h9999_9999;
        step();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({reg_wr_en_o, bus_req_o, hold_o} !== 3'b000)
            $display("FAIL reset_mid_late: got wr_en=%b req=%b hold=%b, want 000", reg_wr_en_o, bus_req_o, hold_o);
        else n_pass++;
        step();
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int fire = 0;
        drive_req(1'b0, 3'd2, 32'h0000_0700, 32'h0, 5'd3);
        step();
        req_valid_i = 1'b0;
        for (int c = 1; c <= 24 && fire == 0; c++) begin
            @(negedge clk);
            if (fault_o) fire = c;
            step();
        end
        n_checks++;
        if (fire != 17) $display("FAIL timeout_cycle: got %0d want 17", fire); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus_req_o, hold_o, fault_addr_o} !== {2'b00, 32'h0000_0700})
            $display("FAIL timeout_idle: got req=%b hold=%b addr=%h, want 0 0 00000700", bus_req_o, hold_o, fault_addr_o);
        else n_pass++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_load("lw", 3'd2, 32'h0000_0100, 5'd5, 32'hDEAD_BEEF, 0);
        test_load("lb", 3'd0, 32'h0000_0103, 5'd1, 32'h80FF_FFFF, 0);
        test_load("lbu", 3'd4, 32'h0000_0103, 5'd2, 32'h80FF_FFFF, 1);
        test_load("lhu", 3'd5, 32'h0000_0102, 5'd11, 32'hBEEF_1234, 0);
        test_load("lh", 3'd1, 32'h0000_0102, 5'd12, 32'h8001_7FFF, 2);
        test_load("lw_x0", 3'd2, 32'h0000_0104, 5'd0, 32'h1234_5678, 0);
        test_store("sb", 3'd0, 32'h0000_0201, 32'h0000_00AB, 3, 4'b0010, 32'hABAB_ABAB);
        test_store("sh", 3'd1, 32'h0000_0102, 32'h1234_CAFE, 0, 4'b1100, 32'hCAFE_CAFE);
        test_store("sw", 3'd2, 32'h0000_0300, 32'h1234_5678, 1, 4'b1111, 32'h1234_5678);
        test_illegal("lw_mis", 1'b0, 3'd2, 32'h0000_0102);
        test_illegal("sh_mis", 1'b1, 3'd1, 32'h0000_0305);
        test_illegal("ld_f3", 1'b0, 3'd6, 32'h0000_0100);
        test_illegal("st_f3", 1'b1, 3'd4, 32'h0000_0100);
        test_flush();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_load("final", 3'd2, 32'h0000_0900, 5'd31, 32'h0BAD_CAFE, 0);
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
